stream_rr_arbiter: RTL



---
 rtl/stream_pkg.sv | 33 +++
 rtl/stream_reg_slice.sv | 50 +++++
 rtl/stream_rr_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared types and helpers for the ready/valid stream blocks.
//
// Contents:
//   arb_state_t    - arbiter lock state (IDLE / LOCKED)
//   id_width()     - width of a source tag for n requesters (at least 1 bit)
//   stream_beat_t  - one beat (data, last, source) at the default stream
//                    widths, for blocks that pass whole beats around
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit tag so ports never collapse
    // to zero width.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BEAT_DATA_WIDTH = 32;
    localparam int BEAT_ID_WIDTH   = 4;

    typedef struct packed {
        logic [BEAT_DATA_WIDTH-1:0] data;
        logic                       last;
        logic [BEAT_ID_WIDTH-1:0]   source;
    } stream_beat_t;

endpackage

// File: rtl/stream_reg_slice.sv
// ---------------------------------------------------------------------------
// stream_reg_slice
// One-entry registered output stage. A load captures a beat and raises
// out_valid; when nothing is loaded and downstream accepts, the entry is
// emptied. The payload registers are only written on a load, so the last
// beat stays visible (with out_valid low) after it drains.
//
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   load                    - capture in_* this edge (caller guarantees room)
//   in_data/in_last/in_source - beat to capture
//   out_ready               - downstream accept
//   out_valid/out_data/out_last/out_source - registered beat
// ---------------------------------------------------------------------------
module stream_reg_slice
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [ID_WIDTH-1:0]   in_source,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ID_WIDTH-1:0]   out_source
);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_source <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_last   <= in_last;
            out_source <= in_source;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
// Round-robin arbiter merging NUM_REQ multi-beat ready/valid streams onto
// one registered output. A requester that wins keeps the channel until its
// last beat is accepted, so packets never interleave. Each output beat is
// tagged with the index of the requester that produced it.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | no packet open; grant goes to first valid requester from rr_ptr
//   LOCKED | packet from owner in progress; only owner may send
//
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   req_valid      - per-requester beat valid
//   req_last       - per-requester final-beat flag
//   req_data       - requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      - per-requester accept (combinational)
//   out_valid/out_last/out_data/out_source - merged registered beat
//   out_ready      - downstream accept
//   busy           - high while a packet is locked
// ---------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_source,
    input  logic                          out_ready,
    output logic                          busy
);

    arb_state_t          state, state_next;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_next;
    logic [ID_WIDTH-1:0] owner, owner_next;
    logic [ID_WIDTH-1:0] pick;
    logic [ID_WIDTH-1:0] grant;
    logic                can_take;
    logic                accept;
    logic                beat_last;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester scanning circularly from start. Walking the
    // offsets from far to near lets the nearest hit overwrite the result.
    // When nothing is valid the result is unused.
    function automatic logic [ID_WIDTH-1:0] rr_first(
        input logic [NUM_REQ-1:0]  valid,
        input logic [ID_WIDTH-1:0] start
    );
        logic [ID_WIDTH-1:0] found;
        logic [ID_WIDTH-1:0] idx;
        found = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(start) + k) % NUM_REQ);
            if (valid[idx]) begin
                found = idx;
            end
        end
        return found;
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] x);
        if (x == ID_WIDTH'(NUM_REQ - 1)) begin
            return '0;
        end
        return x + ID_WIDTH'(1);
    endfunction

    assign can_take = !out_valid || out_ready;
    assign busy     = (state == LOCKED);

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner;
        req_ready   = '0;

        pick  = rr_first(req_valid, rr_ptr);
        grant = (state == LOCKED) ? owner : pick;

        // While locked the owner sees ready even if it has paused, so the
        // channel simply idles instead of being handed to someone else.
        if (!reset && ((state == LOCKED) || (|req_valid))) begin
            req_ready[grant] = can_take;
        end

        accept    = req_valid[grant] && req_ready[grant];
        beat_last = req_last[grant];

        case (state)
            IDLE: begin
                if (accept) begin
                    if (beat_last) begin
                        rr_ptr_next = next_idx(pick);
                    end else begin
                        state_next = LOCKED;
                        owner_next = pick;
                    end
                end
            end
            LOCKED: begin
                if (accept && beat_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = next_idx(owner);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            owner  <= owner_next;
        end
    end

    stream_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_slice (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .in_data    (data_arr[grant]),
        .in_last    (beat_last),
        .in_source  (grant),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_source (out_source)
    );

endmodule
